// File: rtl/alu_16_pkg.sv
// Shared widths, ALU control codes and the response
// record carried through the response buffer.
package alu_16_pkg;

  localparam int ALU_W  = 16;
  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_CTRL_ADD = 4'd0;
  localparam logic [CTRL_W-1:0] ALU_CTRL_SUB = 4'd1;
  localparam logic [CTRL_W-1:0] ALU_CTRL_OR  = 4'd2;
  localparam logic [CTRL_W-1:0] ALU_CTRL_AND = 4'd3;
  localparam logic [CTRL_W-1:0] ALU_CTRL_XOR = 4'd4;
  localparam logic [CTRL_W-1:0] ALU_CTRL_SLT = 4'd5;

  typedef struct packed {
    logic [ALU_W-1:0] s;
    logic             zero;
    logic             overflow;
  } alu_rsp_t;

endpackage

// File: rtl/alu_16_rsp_fifo.sv
// Synchronous FIFO with occupancy count; storage is
// cleared on reset so the head reads zero when idle.
module alu_16_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i)
      wr_d = (wr_q == AW'(DEPTH-1)) ? '0 : wr_q + 1'b1;
    if (pop_i)
      rd_d = (rd_q == AW'(DEPTH-1)) ? '0 : rd_q + 1'b1;
    if (push_i && !pop_i)
      cnt_d = cnt_q + 1'b1;
    else if (pop_i && !push_i)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_i)
        mem_q[wr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/alu_control.sv
// 16-bit combinational ALU: result, zero flag and
// signed overflow for add/subtract.
module alu_control
  import alu_16_pkg::*;
(
  input  logic [ALU_W-1:0]  a,
  input  logic [ALU_W-1:0]  b,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [ALU_W-1:0]  s,
  output logic              zero,
  output logic              overflow
);

  logic [ALU_W-1:0] sum;
  logic [ALU_W-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    s        = '0;
    overflow = 1'b0;
    case (ctrl)
      ALU_CTRL_ADD: begin
        s        = sum;
        overflow = (a[ALU_W-1] == b[ALU_W-1]) &&
                   (sum[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_CTRL_SUB: begin
        s        = diff;
        overflow = (a[ALU_W-1] != b[ALU_W-1]) &&
                   (diff[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_CTRL_OR:  s = a | b;
      ALU_CTRL_AND: s = a & b;
      ALU_CTRL_XOR: s = a ^ b;
      ALU_CTRL_SLT: s = {{(ALU_W-1){1'b0}},
                         ($signed(a) < $signed(b))};
      default:      s = '0;
    endcase
  end

  assign zero = (s == '0);

endmodule

// File: rtl/alu_16_seq_unit.sv
// Flow-controlled ALU front end: one operand stage feeding
// alu_control, results queued in a response FIFO.
module alu_16_seq_unit
  import alu_16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ALU_W-1:0]  req_a,
  input  logic [ALU_W-1:0]  req_b,
  input  logic [CTRL_W-1:0] req_ctrl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ALU_W-1:0]  rsp_s,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic [15:0]       ops_done
);

  logic              s1_valid_q, s1_valid_d;
  logic [ALU_W-1:0]  s1_a_q, s1_b_q;
  logic [CTRL_W-1:0] s1_ctrl_q;
  logic [15:0]       ops_q;

  logic     req_fire, pop, s1_adv;
  logic     fifo_full, fifo_empty;
  alu_rsp_t alu_rsp, head;

  alu_control u_alu (
    .a        (s1_a_q),
    .b        (s1_b_q),
    .ctrl     (s1_ctrl_q),
    .s        (alu_rsp.s),
    .zero     (alu_rsp.zero),
    .overflow (alu_rsp.overflow)
  );

  alu_16_rsp_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(alu_rsp_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s1_adv),
    .pop_i   (pop),
    .wdata_i (alu_rsp),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A full buffer still takes a write when its head leaves.
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign s1_adv    = s1_valid_q && (!fifo_full || pop);
  assign req_ready = !s1_valid_q || s1_adv;
  assign req_fire  = req_valid && req_ready;

  assign rsp_s        = head.s;
  assign rsp_zero     = head.zero;
  assign rsp_overflow = head.overflow;
  assign ops_done     = ops_q;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (req_fire)
      s1_valid_d = 1'b1;
    else if (s1_adv)
      s1_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ctrl_q  <= '0;
      ops_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (req_fire) begin
        s1_a_q    <= req_a;
        s1_b_q    <= req_b;
        s1_ctrl_q <= req_ctrl;
      end
      if (pop)
        ops_q <= ops_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_16_seq_unit.sv
// Directed bench for alu_16_seq_unit: handshake timing,
// backpressure, mid-stream reset and counter wrap.
module tb_alu_16_seq_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ctrl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_s;
  logic        rsp_zero;
  logic        rsp_overflow;
  logic [15:0] ops_done;

  int n_cmp = 0;
  int n_bad = 0;

  alu_16_seq_unit #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ctrl     (req_ctrl),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_s        (rsp_s),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .ops_done     (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (dut.u_fifo.push_i && dut.u_fifo.full_o
          && !dut.u_fifo.pop_i) begin
        n_bad++;
        $display("FAIL push_on_full at %0t", $time);
      end
      if (dut.u_fifo.pop_i && dut.u_fifo.empty_o) begin
        n_bad++;
        $display("FAIL pop_on_empty at %0t", $time);
      end
    end
  end

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue_one(input logic [15:0] a,
                           input logic [15:0] b,
                           input logic [3:0] c,
                           output logic [15:0] s,
                           output bit ok);
    bit acc;
    acc = 1'b0;
    ok  = 1'b0;
    s   = '0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_a = a; req_b = b; req_ctrl = c;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        s  = rsp_s;
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset(2);
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_req_ready got %b want 1", req_ready);
    end
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
    end
    n_cmp++;
    if (ops_done !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_ops_done got %h want 0000", ops_done);
    end
    n_cmp++;
    if ({rsp_s, rsp_zero, rsp_overflow} !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_rsp_data got %h/%b/%b want 0",
               rsp_s, rsp_zero, rsp_overflow);
    end
  endtask

  task automatic test_single_or;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_a = 16'h5555; req_b = 16'hAAAA; req_ctrl = 4'd2;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_accept got %b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early got %b want 0", rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_s, rsp_zero, rsp_overflow}
        !== {1'b1, 16'hFFFF, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL single_rsp got v=%b s=%h z=%b o=%b want v=1 s=ffff z=0 o=0",
               rsp_valid, rsp_s, rsp_zero, rsp_overflow);
    end
    @(negedge clk);
    n_cmp++;
    if (ops_done !== 16'd1) begin
      n_bad++;
      $display("FAIL single_ops_done got %0d want 1", ops_done);
    end
  endtask

  task automatic test_stream;
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] vs [4];
    va = '{16'd0, 16'd53, 16'd1024, 16'd16384};
    vb = '{16'd0, 16'd64, 16'd3516, 16'd16383};
    vs = '{16'h0000, 16'h0075, 16'h0DBC, 16'h7FFF};
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      req_valid = (k < 4);
      if (k < 4) begin
        req_a = va[k]; req_b = vb[k]; req_ctrl = 4'd2;
      end
      @(negedge clk);
      if (k < 4) begin
        n_cmp++;
        if (req_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL stream_ready[%0d] got %b want 1", k, req_ready);
        end
      end
      if (k >= 2) begin
        n_cmp++;
        if ({rsp_valid, rsp_s, rsp_zero, rsp_overflow}
            !== {1'b1, vs[k-2], (k == 2), 1'b0}) begin
          n_bad++;
          $display("FAIL stream_rsp[%0d] got v=%b s=%h z=%b o=%b want v=1 s=%h z=%b o=0",
                   k-2, rsp_valid, rsp_s, rsp_zero, rsp_overflow,
                   vs[k-2], (k == 2));
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, ops_done} !== {1'b0, 16'd5}) begin
      n_bad++;
      $display("FAIL stream_end got v=%b ops=%0d want v=0 ops=5",
               rsp_valid, ops_done);
    end
  endtask

  task automatic test_backpressure;
    int idx, got;
    bit seen;
    logic [17:0] held;
    idx = 0; got = 0; seen = 1'b0; held = '0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      req_valid = (idx < 5);
      req_a = 16'(idx); req_b = 16'h0F00; req_ctrl = 4'd2;
      @(negedge clk);
      if (req_valid && req_ready) idx++;
      if (rsp_valid) begin
        if (!seen) begin
          held = {rsp_s, rsp_zero, rsp_overflow};
          seen = 1'b1;
        end else begin
          n_cmp++;
          if ({rsp_s, rsp_zero, rsp_overflow} !== held) begin
            n_bad++;
            $display("FAIL bp_hold got %h want %h",
                     {rsp_s, rsp_zero, rsp_overflow}, held);
          end
        end
      end
    end
    n_cmp++;
    if (idx != 3 || req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_accept got %0d ready=%b want 3 ready=0",
               idx, req_ready);
    end
    n_cmp++;
    if (held !== {16'h0F00, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL bp_head got %h want %h", held,
               {16'h0F00, 2'b00});
    end
    for (int c = 0; c < 30 && got < 5; c++) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      req_valid = (idx < 5);
      req_a = 16'(idx); req_b = 16'h0F00; req_ctrl = 4'd2;
      @(negedge clk);
      if (c == 0) begin
        n_cmp++;
        if (req_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL bp_release_ready got %b want 1", req_ready);
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_cmp++;
        if (rsp_s !== (16'h0F00 | 16'(got))) begin
          n_bad++;
          $display("FAIL bp_order[%0d] got %h want %h",
                   got, rsp_s, 16'h0F00 | 16'(got));
        end
        got++;
      end
      if (req_valid && req_ready) idx++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (got != 5 || ops_done !== 16'd10) begin
      n_bad++;
      $display("FAIL bp_done got %0d ops=%0d want 5 ops=10",
               got, ops_done);
    end
  endtask

  task automatic test_mid_reset;
    int acc;
    logic [15:0] s;
    bit ok;
    acc = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_a = 16'(c + 1); req_b = 16'h0; req_ctrl = 4'd2;
      @(negedge clk);
      if (req_ready) acc++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, ops_done, req_ready} !== {1'b0, 16'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_state got v=%b ops=%0d rdy=%b want v=0 ops=0 rdy=1",
               rsp_valid, ops_done, req_ready);
    end
    rsp_ready = 1'b1;
    issue_one(16'h0000, 16'hFFFF, 4'd2, s, ok);
    n_cmp++;
    if (!ok || s !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL midrst_first got ok=%b s=%h want ok=1 s=ffff", ok, s);
    end
    n_cmp++;
    if (ops_done !== 16'd1) begin
      n_bad++;
      $display("FAIL midrst_ops got %0d want 1", ops_done);
    end
  endtask

  task automatic test_wrap;
    int acc;
    logic [15:0] s;
    bit ok;
    acc = 0;
    do_reset(2);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_a = 16'h0001; req_b = 16'h0002; req_ctrl = 4'd2;
    for (int c = 0; c < 70000 && acc < 65534; c++) begin
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ops_done !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL wrap_pre got %h want fffe", ops_done);
    end
    issue_one(16'h1200, 16'h0034, 4'd2, s, ok);
    n_cmp++;
    if (!ok || s !== 16'h1234 || ops_done !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_ffff got ok=%b s=%h ops=%h want ok=1 s=1234 ops=ffff",
               ok, s, ops_done);
    end
    issue_one(16'h0000, 16'h0000, 4'd2, s, ok);
    n_cmp++;
    if (!ok || s !== 16'h0000 || ops_done !== 16'h0000) begin
      n_bad++;
      $display("FAIL wrap_0000 got ok=%b s=%h ops=%h want ok=1 s=0000 ops=0000",
               ok, s, ops_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_a = '0; req_b = '0; req_ctrl = '0;
    rsp_ready = 1'b0;
    test_reset;
    test_single_or;
    test_stream;
    test_backpressure;
    test_mid_reset;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
